// File: rtl/matld_pkg.sv
// rtl/matld_pkg.sv - shared constants, FSM state type and element slicing helper for matrix_loader
package matld_pkg;

    localparam int DATASIZE      = 16;
    localparam int REGISTER_SIZE = 4;
    localparam int ELEMS         = REGISTER_SIZE * REGISTER_SIZE;
    localparam int MEMORY_SIZE   = ELEMS * DATASIZE;
    localparam int IDX_W         = $clog2(ELEMS);

    typedef enum logic [2:0] {
        IDLE,
        FILL_A,
        WR_A,
        FILL_B,
        WR_B,
        RD_ISSUE,
        RD_CAP,
        DRAIN
    } state_t;

    // MSB position of element idx; element 0 occupies the top DATASIZE bits.
    function automatic int elem_slice(input logic [IDX_W-1:0] idx);
        return MEMORY_SIZE - 1 - DATASIZE * int'(idx);
    endfunction

endpackage

// File: rtl/matrix_loader_if.sv
// rtl/matrix_loader_if.sv - element input stream and result output stream of matrix_loader
// Signals: in_data/in_valid/in_ready (elements into the loader),
//          out_data/out_valid/out_ready (result elements out of the loader).
// Modports: master = host side, slave = loader side.
interface matrix_loader_if;
    import matld_pkg::*;

    logic [DATASIZE-1:0] in_data;
    logic                in_valid;
    logic                in_ready;
    logic [DATASIZE-1:0] out_data;
    logic                out_valid;
    logic                out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid
    );

endinterface

// File: rtl/matrix_packer.sv
// rtl/matrix_packer.sv - 16-element pack register with indexed write, whole-word load and indexed read
// Ports: clk, reset_l (async active-low), wr_en/wr_idx/wr_data (store one element),
//        ld_en/ld_word (load the full word, takes priority), rd_idx/rd_data (indexed read),
//        word (full packed contents).
module matrix_packer
    import matld_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_l,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [DATASIZE-1:0]    wr_data,
    input  logic                   ld_en,
    input  logic [MEMORY_SIZE-1:0] ld_word,
    input  logic [IDX_W-1:0]       rd_idx,
    output logic [DATASIZE-1:0]    rd_data,
    output logic [MEMORY_SIZE-1:0] word
);

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            word <= '0;
        end else if (ld_en) begin
            word <= ld_word;
        end else if (wr_en) begin
            word[elem_slice(wr_idx) -: DATASIZE] <= wr_data;
        end
    end

    assign rd_data = word[elem_slice(rd_idx) -: DATASIZE];

endmodule

// File: rtl/matrix_loader.sv
// rtl/matrix_loader.sv - packs A and B, writes them to the multiplier bus, captures and streams the product
// Ports: clk, reset_l (async active-low), stream (matrix_loader_if.slave: element in / result out),
//        databus (shared tri-state multiplier bus), busy, select, enable, readwrite, ab_select,
//        keep_b (only when MATLD_KEEP_B_EN is defined: reuse the B already held by the multiplier).
module matrix_loader
    import matld_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_l,
    matrix_loader_if.slave         stream,
    inout  wire [MEMORY_SIZE-1:0]  databus,
    output logic                   busy,
    output logic                   select,
    output logic                   enable,
    output logic                   readwrite,
    output logic                   ab_select
`ifdef MATLD_KEEP_B_EN
    ,
    input  logic                   keep_b
`endif
);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               keep_b_q, keep_b_nxt;
    logic               in_rdy, out_vld, pack_wr, res_ld, bus_oe;
    logic [MEMORY_SIZE-1:0] pack_word;
    logic [DATASIZE-1:0]    res_elem;
    logic [DATASIZE-1:0]    unused_pack_rd;
    logic [MEMORY_SIZE-1:0] unused_res_word;

    // A and B share one pack register: A is on the bus before B filling starts.
    matrix_packer u_pack (
        .clk     (clk),
        .reset_l (reset_l),
        .wr_en   (pack_wr),
        .wr_idx  (idx),
        .wr_data (stream.in_data),
        .ld_en   (1'b0),
        .ld_word ('0),
        .rd_idx  (idx),
        .rd_data (unused_pack_rd),
        .word    (pack_word)
    );

    matrix_packer u_result (
        .clk     (clk),
        .reset_l (reset_l),
        .wr_en   (1'b0),
        .wr_idx  ('0),
        .wr_data ('0),
        .ld_en   (res_ld),
        .ld_word (databus),
        .rd_idx  (idx),
        .rd_data (res_elem),
        .word    (unused_res_word)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state    <= IDLE;
            idx      <= '0;
            keep_b_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            keep_b_q <= keep_b_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        keep_b_nxt = keep_b_q;
        in_rdy     = 1'b0;
        out_vld    = 1'b0;
        pack_wr    = 1'b0;
        res_ld     = 1'b0;
        bus_oe     = 1'b0;
        select     = 1'b0;
        enable     = 1'b0;
        readwrite  = 1'b1;
        ab_select  = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (stream.in_valid) begin
                    pack_wr   = 1'b1;
                    idx_nxt   = IDX_W'(1);
                    state_nxt = FILL_A;
`ifdef MATLD_KEEP_B_EN
                    keep_b_nxt = keep_b;
`else
                    keep_b_nxt = 1'b0;
`endif
                end
            end
            FILL_A, FILL_B: begin
                in_rdy = 1'b1;
                if (stream.in_valid) begin
                    pack_wr = 1'b1;
                    idx_nxt = idx + 1'b1;
                    if (idx == IDX_W'(ELEMS - 1))
                        state_nxt = (state == FILL_A) ? WR_A : WR_B;
                end
            end
            WR_A: begin
                select    = 1'b1;
                enable    = 1'b1;
                bus_oe    = 1'b1;
                state_nxt = keep_b_q ? RD_ISSUE : FILL_B;
            end
            WR_B: begin
                select    = 1'b1;
                enable    = 1'b1;
                ab_select = 1'b1;
                bus_oe    = 1'b1;
                state_nxt = RD_ISSUE;
            end
            RD_ISSUE: begin
                select    = 1'b1;
                enable    = 1'b1;
                readwrite = 1'b0;
                state_nxt = RD_CAP;
            end
            RD_CAP: begin
                // Multiplier has been driving since RD_ISSUE; capture on this closing edge.
                select    = 1'b1;
                enable    = 1'b1;
                readwrite = 1'b0;
                res_ld    = 1'b1;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                out_vld = 1'b1;
                if (stream.out_ready) begin
                    idx_nxt = idx + 1'b1;
                    if (idx == IDX_W'(ELEMS - 1))
                        state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate with reset so nothing is accepted while reset is held.
    assign stream.in_ready  = in_rdy & reset_l;
    assign stream.out_valid = out_vld;
    assign stream.out_data  = out_vld ? res_elem : '0;
    assign busy             = (state != IDLE);
    assign databus          = bus_oe ? pack_word : {MEMORY_SIZE{1'bz}};

endmodule

// File: tb/tb_matrix_loader.sv
// tb/tb_matrix_loader.sv - directed self-checking bench for matrix_loader with a 4x4 multiplier bus model
module tb_matrix_loader;
    import matld_pkg::*;

    logic clk = 1'b0;
    logic reset_l = 1'b0;
    wire [MEMORY_SIZE-1:0] databus;
    logic busy, select, enable, readwrite, ab_select;
`ifdef MATLD_KEEP_B_EN
    logic keep_b = 1'b0;
`endif

    int total = 0;
    int bad = 0;

    matrix_loader_if sif ();

    matrix_loader dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .stream    (sif.slave),
        .databus   (databus),
        .busy      (busy),
        .select    (select),
        .enable    (enable),
        .readwrite (readwrite),
        .ab_select (ab_select)
`ifdef MATLD_KEEP_B_EN
        ,
        .keep_b    (keep_b)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier model: latches operands on write cycles, drives the product on read cycles.
    logic [MEMORY_SIZE-1:0] mul_a = '0;
    logic [MEMORY_SIZE-1:0] mul_b = '0;
    logic [MEMORY_SIZE-1:0] mul_res;
    int wr_b_cnt = 0;

    function automatic logic [MEMORY_SIZE-1:0] matmul(input logic [MEMORY_SIZE-1:0] a,
                                                      input logic [MEMORY_SIZE-1:0] b);
        logic [MEMORY_SIZE-1:0] r;
        logic [15:0] acc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc + 16'(a[255-16*(4*i+k) -: 16] * b[255-16*(4*k+j) -: 16]);
                r[255-16*(4*i+j) -: 16] = acc;
            end
        end
        return r;
    endfunction

    assign mul_res = matmul(mul_a, mul_b);
    assign databus = (select && enable && !readwrite) ? mul_res : {MEMORY_SIZE{1'bz}};

    always @(posedge clk) begin
        if (select && enable && readwrite) begin
            if (ab_select) begin
                mul_b    <= databus;
                wr_b_cnt <= wr_b_cnt + 1;
            end else begin
                mul_a    <= databus;
            end
        end
    end

    task automatic check(input string tag, input logic [MEMORY_SIZE-1:0] obs,
                         input logic [MEMORY_SIZE-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        sif.in_valid = 1'b1;
        sif.in_data  = d;
        while (!sif.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        sif.in_valid = 1'b0;
    endtask

    task automatic send_matrix(input logic [MEMORY_SIZE-1:0] w, input int count);
        for (int i = 0; i < count; i++)
            send(w[255-16*i -: 16]);
    endtask

    task automatic drain(input string tag, input logic [MEMORY_SIZE-1:0] exp, input bit toggle);
        logic [15:0] held;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            int n = 0;
            while (!sif.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("%s_valid%0d", tag, k), 256'(sif.out_valid), 256'(1));
            check($sformatf("%s_data%0d", tag, k), 256'(sif.out_data), 256'(exp[255-16*k -: 16]));
            if (toggle) begin
                held = sif.out_data;
                sif.out_ready = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check($sformatf("%s_hold%0d", tag, k), 256'({sif.out_valid, sif.out_data}),
                      256'({1'b1, held}));
            end
            sif.out_ready = 1'b1;
            @(posedge clk);
            #1;
            sif.out_ready = 1'b0;
            @(negedge clk);
        end
        check({tag, "_busy_end"}, 256'(busy), 256'(0));
        check({tag, "_valid_end"}, 256'(sif.out_valid), 256'(0));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 256'(sif.in_ready), 256'(0));
        check({tag, "_out_valid"}, 256'(sif.out_valid), 256'(0));
        check({tag, "_out_data"}, 256'(sif.out_data), 256'(0));
        check({tag, "_busy"}, 256'(busy), 256'(0));
        check({tag, "_ctrl"}, 256'({select, enable, readwrite, ab_select}), 256'(4'b0010));
        check({tag, "_state"}, 256'(dut.state), 256'(IDLE));
        check({tag, "_bus_oe"}, 256'(dut.bus_oe), 256'(0));
    endtask

    logic [MEMORY_SIZE-1:0] ident, seq, all2, all3, all100, exp24, two_i, seq2;
    int wr_b_before;

    initial begin
        for (int i = 0; i < 16; i++) begin
            ident[255-16*i -: 16]  = (i % 5 == 0) ? 16'd1 : 16'd0;
            two_i[255-16*i -: 16]  = (i % 5 == 0) ? 16'd2 : 16'd0;
            seq[255-16*i -: 16]    = 16'(i + 1);
            seq2[255-16*i -: 16]   = 16'(2 * (i + 1));
            all2[255-16*i -: 16]   = 16'd2;
            all3[255-16*i -: 16]   = 16'd3;
            all100[255-16*i -: 16] = 16'h0100;
            exp24[255-16*i -: 16]  = 16'h0018;
        end
        sif.in_valid  = 1'b0;
        sif.in_data   = '0;
        sif.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 256'(sif.in_ready), 256'(1));
        check("idle_busy", 256'(busy), 256'(0));

        // 1: identity * 1..16
        wr_b_before = wr_b_cnt;
        send_matrix(ident, 16);
        send_matrix(seq, 16);
        drain("t1", seq, 1'b0);
        check("t1_mul_a", mul_a, ident);
        check("t1_mul_b", mul_b, seq);
        check("t1_wr_b", 256'(wr_b_cnt - wr_b_before), 256'(1));

        // 2: all 2 * all 3
        send_matrix(all2, 16);
        send_matrix(all3, 16);
        drain("t2", exp24, 1'b0);

        // 3: 0x0100 squared truncates to zero
        send_matrix(all100, 16);
        send_matrix(all100, 16);
        drain("t3", '0, 1'b0);

        // 4: stalled drain
        send_matrix(ident, 16);
        send_matrix(seq, 16);
        drain("t4", seq, 1'b1);

        // 5: reset partway through B, then full reload
        send_matrix(all2, 16);
        send_matrix(all3, 7);
        @(negedge clk);
        reset_l = 1'b0;
        #1;
        check_reset_outputs("t5_rst");
        @(negedge clk);
        reset_l = 1'b1;
        send_matrix(ident, 16);
        send_matrix(seq, 16);
        drain("t5", seq, 1'b0);

`ifdef MATLD_KEEP_B_EN
        // 6: reuse B = 1..16 with A = 2*I
        wr_b_before = wr_b_cnt;
        @(negedge clk);
        keep_b = 1'b1;
        send_matrix(two_i, 1);
        keep_b = 1'b0;
        for (int i = 1; i < 16; i++)
            send(two_i[255-16*i -: 16]);
        drain("t6", seq2, 1'b0);
        check("t6_no_wr_b", 256'(wr_b_cnt - wr_b_before), 256'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
